br_update_queue: RTL
====================

# br_update_queue

Buffers resolved branch outcomes from the integer execution lanes and feeds them, one per cycle, to the branch predictor's PHT and local-history write port. Up to IN_NUM results arrive per cycle. The queue computes the saturated counter value and any repaired history at enqueue, then drains them in order over a valid/ready handshake. This removes same-bank write conflicts and dropped same-index updates in the predictor; it sits between the execution stage result bus and the predictor's update port.

## Interface
- IN_NUM, 2, branch results accepted per cycle (one lane per integer issue lane)
- DEPTH, 8, queue entries; power of two, ≥ 2·IN_NUM
- ADDR_WIDTH, 32, branch address width
- INSN_SHIFT, 2, log2 instruction byte width
- INDEX_OFFSET, 0, extra low address bits skipped before the index
- INDEX_WIDTH, 8, PHT/history table index width
- HIST_WIDTH, 4, per-address history width
- CTR_WIDTH, 2, saturating counter width
- clk  in  1  clock; all state updates on rising edge
- rstN  in  1  asynchronous active-low reset
- inValid[IN_NUM]  in  1  result valid per lane
- inAddr[IN_NUM]  in  ADDR_WIDTH  branch address
- inTaken[IN_NUM]  in  1  resolved direction
- inMispred[IN_NUM]  in  1  resolved mispredict
- inIsCondBr[IN_NUM]  in  1  conditional branch
- inPrevHist[IN_NUM]  in  HIST_WIDTH  history used at prediction
- inPrevCtr[IN_NUM]  in  CTR_WIDTH  counter used at prediction
- almostFull  out  1  free entries < IN_NUM; producer must present no results while high
- outValid  out  1  head entry valid
- outReady  in  1  predictor accepts head
- outIndex  out  INDEX_WIDTH  PHT/history index
- outHist  out  HIST_WIDTH  counter select within entry (prediction-time history)
- outCtr  out  CTR_WIDTH  new counter value
- outHistWE  out  1  history repair required
- outHistVal  out  HIST_WIDTH  repaired history
- dropCount  out  16  saturating dropped-result count (macro only; else tied 0)

## Operation
- Index: inAddr[INDEX_WIDTH-1+INSN_SHIFT+INDEX_OFFSET : INSN_SHIFT+INDEX_OFFSET].
- Counter: taken → min(prev+1, 2^CTR_WIDTH-1); not taken → max(prev-1, 0).
- outHistWE = inMispred && inIsCondBr; outHistVal = {inPrevHist[HIST_WIDTH-1:1], inTaken}; 0 when outHistWE = 0.
- Enqueue: valid lanes are compacted in lane order (lane 0 first) into consecutive tail slots. Invalid lanes consume no slot.
- Same-index results in one cycle both enqueue as separate entries, lane 0 first.
- Circular buffer: head/tail pointers wrap modulo DEPTH; count width log2(DEPTH)+1.
- Dequeue when outValid && outReady; head advances by 1.
- Overflow: a valid lane is dropped if it finds no free slot after dequeue of this cycle. Earlier lanes take priority. Each drop increments dropCount (macro).
- No flush: every result is architecturally resolved.

## Timing
- Reset (rstN low, asynchronous): head=tail=count=0, outValid=0, almostFull=0, dropCount=0. Storage contents are don't-care. Outputs other than outValid may hold any value while outValid=0.
- Latency: a result enqueued at edge N is at the head with outValid=1 after edge N (empty-queue case), i.e. 1 cycle.
- outValid = (count != 0), derived from registered state only. Head fields are read combinationally from registered storage; no combinational path from in* to out*.
- almostFull depends on registered count only.
- Simultaneous enqueue and dequeue at count=DEPTH: the dequeued slot is reusable the same edge. The net count change is enqueued minus dequeued.
- outReady low: the head and all out* fields hold stable.
- Reset deasserted mid-stream: the queue restarts empty. Accepted results are lost by design.

## Configuration
- BR_UPDATE_DROP_COUNT_EN defined: dropCount is a 16-bit counter that saturates at 0xFFFF, increments by the number of dropped lanes per cycle, and clears on reset.
- Undefined: no counter logic; dropCount = 0. Drop behaviour is unchanged.

## Structure
- Shared FetchUnit types package: BrUpdateEntry struct (index, hist, ctr, histWE, histVal) and constants for INDEX_WIDTH/HIST_WIDTH/CTR_WIDTH consistent with the predictor's PHT and history index types.
- Sub-module br_update_entry_gen, instanced per lane: combinational index extraction, saturating counter and history repair from one input lane.

## Test plan
- Single lane 0 result, addr 0x100, taken, prevCtr 1: next cycle outValid=1, outIndex=0x40, outCtr=2, outHistWE=0.
- Both lanes same addr 0x200, lane0 taken prevCtr 3, lane1 not-taken prevCtr 0, outReady=1: two entries in order; outCtr=3 then 0, both index 0x80.
- Mispredict cond branch, prevHist 0b1010, taken: outHistWE=1, outHistVal=0b1011.
- outReady=0, fill 8 entries: almostFull=1 at count 7. An extra 2-lane burst at count 7 stores lane 0 and drops lane 1; dropCount=1 with the macro, 0 without.
- Full queue, outReady=1, 1 new result: count stays 8, FIFO order preserved across pointer wrap.
- Assert rstN low mid-stream with 5 entries: outValid=0 immediately (asynchronous); after release the queue is empty and dropCount=0.

Source files
------------

// File: rtl/br_update_queue_pkg.sv
// Shared fetch-unit types for the branch update path.
// Holds the PHT/history geometry constants used by the predictor and the
// BrUpdateEntry record. The queue stores one BrUpdateEntry per resolved branch
// and the predictor consumes it on its update port.
// Contents:
//   BR_INDEX_WIDTH / BR_HIST_WIDTH / BR_CTR_WIDTH : predictor table geometry
//   BrUpdateEntry : one precomputed predictor update
//   satCounter    : saturating up/down step of a 2-bit-style counter
package br_update_queue_pkg;

  localparam int BR_INDEX_WIDTH = 8;
  localparam int BR_HIST_WIDTH  = 4;
  localparam int BR_CTR_WIDTH   = 2;

  typedef struct packed {
    logic [BR_INDEX_WIDTH-1:0] index;
    logic [BR_HIST_WIDTH-1:0]  hist;
    logic [BR_CTR_WIDTH-1:0]   ctr;
    logic                      histWE;
    logic [BR_HIST_WIDTH-1:0]  histVal;
  } BrUpdateEntry;

  // Counter moves one step toward the resolved direction and sticks at the rails.
  function automatic logic [BR_CTR_WIDTH-1:0] satCounter(
    input logic [BR_CTR_WIDTH-1:0] prev,
    input logic                    taken
  );
    logic [BR_CTR_WIDTH-1:0] next;
    next = prev;
    if (taken) begin
      if (prev != '1) next = prev + 1'b1;
    end else begin
      if (prev != '0) next = prev - 1'b1;
    end
    return next;
  endfunction

endpackage

// File: rtl/br_update_queue_entry_gen.sv
// br_update_entry_gen: turns one resolved branch lane into a predictor update.
// Purely combinational; one instance per execution lane.
// Ports:
//   addr      in  branch address
//   taken     in  resolved direction
//   mispred   in  resolved mispredict
//   isCondBr  in  conditional branch flag
//   prevHist  in  local history used at prediction time
//   prevCtr   in  counter value used at prediction time
//   entry     out precomputed update (index, hist, new ctr, history repair)
module br_update_entry_gen
  import br_update_queue_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int INSN_SHIFT   = 2,
  parameter int INDEX_OFFSET = 0
) (
  input  logic [ADDR_WIDTH-1:0]    addr,
  input  logic                     taken,
  input  logic                     mispred,
  input  logic                     isCondBr,
  input  logic [BR_HIST_WIDTH-1:0] prevHist,
  input  logic [BR_CTR_WIDTH-1:0]  prevCtr,
  output BrUpdateEntry             entry
);

  localparam int INDEX_LSB = INSN_SHIFT + INDEX_OFFSET;

  // Address bits outside the index window do not contribute to the update.
  logic unusedAddr;
  assign unusedAddr = ^addr;

  // Only a mispredicted conditional branch needs its local history repaired:
  // the speculative shift-in is replaced by the real outcome.
  always_comb begin
    entry         = '0;
    entry.index   = addr[INDEX_LSB +: BR_INDEX_WIDTH];
    entry.hist    = prevHist;
    entry.ctr     = satCounter(prevCtr, taken);
    entry.histWE  = mispred & isCondBr;
    if (entry.histWE) begin
      entry.histVal = {prevHist[BR_HIST_WIDTH-1:1], taken};
    end
  end

endmodule

// File: rtl/br_update_queue.sv
// br_update_queue: buffers resolved branch outcomes from the execution lanes
// and drains them one per cycle into the predictor's PHT/history update port.
// Counter saturation and history repair are computed at enqueue so the head
// entry is ready to write as-is.
// Optional feature macro: BR_UPDATE_DROP_COUNT_EN enables the 16-bit
// saturating dropped-result counter; otherwise dropCount is tied to 0.
// Ports:
//   clk, rstN          clock, asynchronous active-low reset
//   inValid..inPrevCtr per-lane branch results (IN_NUM lanes)
//   almostFull         fewer than IN_NUM free entries
//   outValid/outReady  head handshake toward the predictor
//   outIndex..outHistVal head entry fields
//   dropCount          saturating count of results lost to overflow
module br_update_queue
  import br_update_queue_pkg::*;
#(
  parameter int IN_NUM       = 2,
  parameter int DEPTH        = 8,
  parameter int ADDR_WIDTH   = 32,
  parameter int INSN_SHIFT   = 2,
  parameter int INDEX_OFFSET = 0,
  parameter int INDEX_WIDTH  = BR_INDEX_WIDTH,
  parameter int HIST_WIDTH   = BR_HIST_WIDTH,
  parameter int CTR_WIDTH    = BR_CTR_WIDTH
) (
  input  logic                             clk,
  input  logic                             rstN,
  input  logic [IN_NUM-1:0]                inValid,
  input  logic [IN_NUM-1:0][ADDR_WIDTH-1:0] inAddr,
  input  logic [IN_NUM-1:0]                inTaken,
  input  logic [IN_NUM-1:0]                inMispred,
  input  logic [IN_NUM-1:0]                inIsCondBr,
  input  logic [IN_NUM-1:0][HIST_WIDTH-1:0] inPrevHist,
  input  logic [IN_NUM-1:0][CTR_WIDTH-1:0]  inPrevCtr,
  output logic                             almostFull,
  output logic                             outValid,
  input  logic                             outReady,
  output logic [INDEX_WIDTH-1:0]           outIndex,
  output logic [HIST_WIDTH-1:0]            outHist,
  output logic [CTR_WIDTH-1:0]             outCtr,
  output logic                             outHistWE,
  output logic [HIST_WIDTH-1:0]            outHistVal,
  output logic [15:0]                      dropCount
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  BrUpdateEntry storage [DEPTH];
  BrUpdateEntry laneEntry [IN_NUM];
  BrUpdateEntry headEntry;

  logic             deq;
  logic [CNT_W-1:0] freeSlots;
  logic [CNT_W-1:0] validSeen;
  logic [CNT_W-1:0] enqNum;
  logic [IN_NUM-1:0] laneAccept;
  logic [PTR_W-1:0] slotIdx [IN_NUM];

  // One entry generator per lane; all update math happens before storage.
  for (genvar g = 0; g < IN_NUM; g++) begin : genLane
    br_update_entry_gen #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .INSN_SHIFT  (INSN_SHIFT),
      .INDEX_OFFSET(INDEX_OFFSET)
    ) entryGen (
      .addr    (inAddr[g]),
      .taken   (inTaken[g]),
      .mispred (inMispred[g]),
      .isCondBr(inIsCondBr[g]),
      .prevHist(inPrevHist[g]),
      .prevCtr (inPrevCtr[g]),
      .entry   (laneEntry[g])
    );
  end

  assign outValid   = (count != '0);
  assign deq        = outValid & outReady;
  assign almostFull = (CNT_W'(DEPTH) - count) < CNT_W'(IN_NUM);

  // Lane compaction: each valid lane's slot offset is the number of valid lanes
  // ahead of it. Because acceptance is in lane order, a lane fits exactly when
  // that offset is below the free space left after this cycle's dequeue, so a
  // slot freed by the head is reusable on the same edge.
  always_comb begin
    freeSlots = CNT_W'(DEPTH) - count + CNT_W'(deq);
    validSeen = '0;
    enqNum    = '0;
    for (int i = 0; i < IN_NUM; i++) begin
      slotIdx[i]    = tail + validSeen[PTR_W-1:0];
      laneAccept[i] = inValid[i] && (validSeen < freeSlots);
      if (inValid[i]) validSeen = validSeen + 1'b1;
      if (laneAccept[i]) enqNum = enqNum + 1'b1;
    end
  end

  // Storage holds no reset; only entries between head and tail are meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < IN_NUM; i++) begin
      if (laneAccept[i]) storage[slotIdx[i]] <= laneEntry[i];
    end
  end

  // Pointers wrap naturally at DEPTH; count carries the extra bit for full.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(deq);
      tail  <= tail + enqNum[PTR_W-1:0];
      count <= count + enqNum - CNT_W'(deq);
    end
  end

  assign headEntry  = storage[head];
  assign outIndex   = headEntry.index;
  assign outHist    = headEntry.hist;
  assign outCtr     = headEntry.ctr;
  assign outHistWE  = headEntry.histWE;
  assign outHistVal = headEntry.histVal;

`ifdef BR_UPDATE_DROP_COUNT_EN
  logic [CNT_W-1:0] dropNum;
  logic [16:0]      dropSum;

  assign dropNum = validSeen - enqNum;
  assign dropSum = {1'b0, dropCount} + 17'(dropNum);

  // Diagnostic drop counter; sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      dropCount <= '0;
    end else if (dropSum[16]) begin
      dropCount <= 16'hFFFF;
    end else begin
      dropCount <= dropSum[15:0];
    end
  end
`else
  assign dropCount = '0;
`endif

endmodule
